// File: rtl/video_timing_if.sv
// Raster timing bundle from the pixel-clock timing generator to the video layers and DAC pins.
// The master drives every signal; phase is the horizontal FSM state (0 active, 1 fp, 2 sync, 3 bp).
interface video_timing_if;
    logic [9:0] hPos;
    logic [9:0] vPos;
    logic [9:0] nextVPos;
    logic       displayActive;
    logic       hsync;
    logic       vsync;
    logic       hsyncStarting;
    logic       nextFrameActive;
    logic       lineStarting;
    logic       lineEnding;
    logic       frameStarting;
    logic [1:0] phase;

    // No handshake: the generator free-runs and every strobe is a one-cycle pulse
    // that the consumer must act on in the cycle it is high; there is no back-pressure.
    modport master (
        output hPos, vPos, nextVPos, displayActive, hsync, vsync, hsyncStarting,
        output nextFrameActive, lineStarting, lineEnding, frameStarting, phase
    );

    modport slave (
        input hPos, vPos, nextVPos, displayActive, hsync, vsync, hsyncStarting,
        input nextFrameActive, lineStarting, lineEnding, frameStarting, phase
    );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator: horizontal/vertical counters, VGA syncs and the fetch strobes
// for the tile background fetcher. Every output is a register describing the hPos/vPos cycle.
module video_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FETCH_LEAD = 2
) (
    input  logic          clkPixel,
    input  logic          resetN,
    video_timing_if.master vid
);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Totals may reach 1024, so only "last index" forms are narrowed to 10 bits.
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] LS_POS       = 10'(H_TOTAL - FETCH_LEAD - 1);
    localparam logic [9:0] LE_POS       = 10'(H_ACTIVE - FETCH_LEAD - 1);

    logic [9:0] hPos, vPos, nextVPos;
    logic       displayActive, hsync, vsync, hsyncStarting, nextFrameActive;
    logic       lineStarting, lineEnding, frameStarting;
    phase_t     phase;

    logic [9:0] hNext, vNext, nextVNext;
    phase_t     phaseNext;

    // Everything registered is computed from the coming cycle's position so that all
    // outputs line up with the hPos/vPos they are reported alongside.
    always_comb begin
        hNext     = (hPos == H_LAST) ? 10'd0 : hPos + 10'd1;
        vNext     = vPos;
        if (hPos == H_LAST) begin
            vNext = (vPos == V_LAST) ? 10'd0 : vPos + 10'd1;
        end
        nextVNext = nextVPos;
        if (hNext == H_ACT) begin
            nextVNext = (vNext == V_LAST) ? 10'd0 : vNext + 10'd1;
        end
        // Later phases win on coinciding boundaries so a zero-width porch is skipped.
        phaseNext = phase;
        if (hNext == H_BP_START) begin
            phaseNext = PH_BP;
        end else if (hNext == H_SYNC_START) begin
            phaseNext = PH_SYNC;
        end else if (hNext == H_ACT) begin
            phaseNext = PH_FP;
        end else if (hNext == 10'd0) begin
            phaseNext = PH_ACTIVE;
        end
    end

    always_ff @(posedge clkPixel) begin
        if (!resetN) begin
            hPos            <= 10'd0;
            vPos            <= V_LAST;
            phase           <= PH_ACTIVE;
            hsync           <= 1'b1;
            vsync           <= 1'b1;
            nextVPos        <= V_LAST;
            nextFrameActive <= 1'b0;
            displayActive   <= 1'b0;
            hsyncStarting   <= 1'b0;
            lineStarting    <= 1'b0;
            lineEnding      <= 1'b0;
            frameStarting   <= 1'b0;
        end else begin
            hPos            <= hNext;
            vPos            <= vNext;
            phase           <= phaseNext;
            hsync           <= (phaseNext != PH_SYNC);
            vsync           <= !((vNext >= V_SYNC_START) && (vNext <= V_SYNC_LAST));
            nextVPos        <= nextVNext;
            nextFrameActive <= (nextVNext < V_ACT);
            displayActive   <= (hNext < H_ACT) && (vNext < V_ACT);
            hsyncStarting   <= (hNext == H_SYNC_START);
            lineStarting    <= (hNext == LS_POS) && (nextVNext < V_ACT);
            lineEnding      <= (hNext == LE_POS) && (vNext < V_ACT);
            frameStarting   <= (hNext == 10'd0) && (vNext == 10'd0);
        end
    end

    assign vid.hPos            = hPos;
    assign vid.vPos            = vPos;
    assign vid.nextVPos        = nextVPos;
    assign vid.displayActive   = displayActive;
    assign vid.hsync           = hsync;
    assign vid.vsync           = vsync;
    assign vid.hsyncStarting   = hsyncStarting;
    assign vid.nextFrameActive = nextFrameActive;
    assign vid.lineStarting    = lineStarting;
    assign vid.lineEnding      = lineEnding;
    assign vid.frameStarting   = frameStarting;
    assign vid.phase           = phase;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: default, tiny and tall-frame instances on one clock and reset,
// each compared every cycle with an arithmetic raster model indexed by cycles since reset.
module tb_video_timing;

    typedef struct packed {
        logic [9:0] hPos;
        logic [9:0] vPos;
        logic [9:0] nextVPos;
        logic       displayActive;
        logic       hsync;
        logic       vsync;
        logic       hsyncStarting;
        logic       nextFrameActive;
        logic       lineStarting;
        logic       lineEnding;
        logic       frameStarting;
    } obs_t;

    logic clkPixel = 1'b0;
    logic resetN   = 1'b0;
    always #5 clkPixel = ~clkPixel;

    video_timing_if dvD ();
    video_timing_if dvT ();
    video_timing_if dvL ();

    video_timing dutD (.clkPixel(clkPixel), .resetN(resetN), .vid(dvD));
    video_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .FETCH_LEAD(2))
        dutT (.clkPixel(clkPixel), .resetN(resetN), .vid(dvT));
    video_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(3))
        dutL (.clkPixel(clkPixel), .resetN(resetN), .vid(dvL));

    obs_t obsD, obsT, obsL;
    assign obsD = {dvD.hPos, dvD.vPos, dvD.nextVPos, dvD.displayActive, dvD.hsync, dvD.vsync,
                   dvD.hsyncStarting, dvD.nextFrameActive, dvD.lineStarting, dvD.lineEnding,
                   dvD.frameStarting};
    assign obsT = {dvT.hPos, dvT.vPos, dvT.nextVPos, dvT.displayActive, dvT.hsync, dvT.vsync,
                   dvT.hsyncStarting, dvT.nextFrameActive, dvT.lineStarting, dvT.lineEnding,
                   dvT.frameStarting};
    assign obsL = {dvL.hPos, dvL.vPos, dvL.nextVPos, dvL.displayActive, dvL.hsync, dvL.vsync,
                   dvL.hsyncStarting, dvL.nextFrameActive, dvL.lineStarting, dvL.lineEnding,
                   dvL.frameStarting};

    int checks   = 0;
    int failures = 0;
    int t        = 0;   // clock edges since the last edge that saw reset

    // Raster position is a pure function of t: line index t/H_TOTAL, starting one line
    // before line 0; the "next line" index flips to v+1 from the first blanking pixel.
    function automatic obs_t model(int tt, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb, int fl);
        int   ht, vt, h, v, nv;
        obs_t o;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h  = tt % ht;
        v  = (tt / ht + vt - 1) % vt;
        nv = (h >= ha) ? (v + 1) % vt : v;
        o.hPos            = 10'(h);
        o.vPos            = 10'(v);
        o.nextVPos        = 10'(nv);
        o.displayActive   = (h < ha) && (v < va);
        o.hsync           = !((h >= ha + hf) && (h < ha + hf + hs));
        o.vsync           = !((v >= va + vf) && (v < va + vf + vs));
        o.hsyncStarting   = (h == ha + hf);
        o.nextFrameActive = (nv < va);
        o.lineStarting    = (h == ht - fl - 1) && (nv < va);
        o.lineEnding      = (h == ha - fl - 1) && (v < va);
        o.frameStarting   = (h == 0) && (v == 0);
        return o;
    endfunction

    task automatic check_obs(string tag, obs_t got, obs_t exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
        end
    endtask

    task automatic check_int(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Tallies gathered during the long post-reset run.
    logic collect = 1'b0;
    int tLs = 0, tLe = 0, tHs = 0, lLs = 0, lLe = 0, lHs = 0;
    int widthViol = 0;
    logic [3:0] prevD = '0, prevT = '0, prevL = '0;
    int dHs = -1, dLe = -1, dLs = -1, dNv = -1, dHsyncLoMin = -1, dHsyncLoCnt = 0;
    int dFs = -1, fsT1 = -1, fsT2 = -1, fsL1 = -1, fsL2 = -1;
    int vsLoMin = 9999, vsLoMax = -1;
    int ls478 = 0, ls479 = 0, le479 = 0, ls524 = 0, nv524 = -1;

    task automatic tick();
        logic [3:0] pD, pT, pL;
        @(posedge clkPixel);
        t = resetN ? t + 1 : 0;
        @(negedge clkPixel);
        check_obs("dflt", obsD, model(t, 640, 16, 96, 48, 480, 10, 2, 33, 2));
        check_obs("tiny", obsT, model(t, 8, 2, 2, 3, 4, 1, 1, 1, 2));
        check_obs("tall", obsL, model(t, 8, 2, 2, 3, 480, 10, 2, 33, 2));

        pD = {dvD.hsyncStarting, dvD.lineStarting, dvD.lineEnding, dvD.frameStarting};
        pT = {dvT.hsyncStarting, dvT.lineStarting, dvT.lineEnding, dvT.frameStarting};
        pL = {dvL.hsyncStarting, dvL.lineStarting, dvL.lineEnding, dvL.frameStarting};
        if (|(pD & prevD) || |(pT & prevT) || |(pL & prevL)) widthViol++;
        prevD = pD; prevT = pT; prevL = pL;

        if (!resetN) dFs = -1;
        else if (dvD.frameStarting && dFs < 0) dFs = t;

        if (collect) begin
            if (t >= 1 && t <= 2 * 105) begin
                tLs += int'(dvT.lineStarting);
                tLe += int'(dvT.lineEnding);
                tHs += int'(dvT.hsyncStarting);
            end
            if (t >= 1 && t <= 2 * 7875) begin
                lLs += int'(dvL.lineStarting);
                lLe += int'(dvL.lineEnding);
                lHs += int'(dvL.hsyncStarting);
                if (!dvL.vsync) begin
                    if (int'(dvL.vPos) < vsLoMin) vsLoMin = int'(dvL.vPos);
                    if (int'(dvL.vPos) > vsLoMax) vsLoMax = int'(dvL.vPos);
                end
            end
            if (dvL.lineStarting && dvL.vPos == 10'd478) ls478 = 1;
            if (dvL.lineStarting && dvL.vPos == 10'd479) ls479 = 1;
            if (dvL.lineEnding && dvL.vPos == 10'd479) le479 = 1;
            if (dvL.lineStarting && dvL.vPos == 10'd524) begin
                ls524 = 1;
                nv524 = int'(dvL.nextVPos);
            end
            if (dvT.frameStarting) begin
                if (fsT1 < 0) fsT1 = t; else if (fsT2 < 0) fsT2 = t;
            end
            if (dvL.frameStarting) begin
                if (fsL1 < 0) fsL1 = t; else if (fsL2 < 0) fsL2 = t;
            end
            if (dvD.vPos == 10'd0) begin
                if (dvD.hsyncStarting && dHs < 0) dHs = int'(dvD.hPos);
                if (dvD.lineEnding && dLe < 0) dLe = int'(dvD.hPos);
                if (dvD.lineStarting && dLs < 0) dLs = int'(dvD.hPos);
                if (dvD.nextVPos == 10'd1 && dNv < 0) dNv = int'(dvD.hPos);
                if (!dvD.hsync) begin
                    if (dHsyncLoMin < 0) dHsyncLoMin = int'(dvD.hPos);
                    dHsyncLoCnt++;
                end
            end
        end
    endtask

    obs_t rstD;
    int   n;

    initial begin
        rstD = '{hPos: 10'd0, vPos: 10'd524, nextVPos: 10'd524, displayActive: 1'b0,
                 hsync: 1'b1, vsync: 1'b1, hsyncStarting: 1'b0, nextFrameActive: 1'b0,
                 lineStarting: 1'b0, lineEnding: 1'b0, frameStarting: 1'b0};

        // Power-on reset held for three cycles.
        resetN = 1'b0;
        repeat (3) begin
            tick();
            check_obs("reset_hold", obsD, rstD);
        end

        // Long run: two tall frames plus change, covering default lines 0..19.
        resetN  = 1'b1;
        collect = 1'b1;
        repeat (16000) tick();
        collect = 1'b0;

        check_int("dflt_first_frame", dFs, 800);
        check_int("dflt_hsyncStarting_h", dHs, 656);
        check_int("dflt_hsync_low_first", dHsyncLoMin, 656);
        check_int("dflt_hsync_low_len", dHsyncLoCnt, 96);
        check_int("dflt_nextVPos_h", dNv, 640);
        check_int("dflt_lineEnding_h", dLe, 637);
        check_int("dflt_lineStarting_h", dLs, 797);

        check_int("tiny_lineStarting_cnt", tLs, 8);
        check_int("tiny_lineEnding_cnt", tLe, 8);
        check_int("tiny_hsyncStarting_cnt", tHs, 14);
        check_int("tiny_frame_period", fsT2 - fsT1, 105);

        check_int("tall_lineStarting_cnt", lLs, 960);
        check_int("tall_lineEnding_cnt", lLe, 960);
        check_int("tall_hsyncStarting_cnt", lHs, 1050);
        check_int("tall_vsync_low_min", vsLoMin, 490);
        check_int("tall_vsync_low_max", vsLoMax, 491);
        check_int("tall_ls_478", ls478, 1);
        check_int("tall_ls_479", ls479, 0);
        check_int("tall_le_479", le479, 1);
        check_int("tall_ls_524", ls524, 1);
        check_int("tall_nextVPos_524", nv524, 0);
        check_int("tall_frame_period", fsL2 - fsL1, 7875);
        check_int("pulse_width", widthViol, 0);

        // Random aborting resets at random points of the raster.
        for (int k = 0; k < 6; k++) begin
            n = int'($urandom_range(50, 3000));
            repeat (n) tick();
            resetN = 1'b0;
            n = int'($urandom_range(1, 3));
            repeat (n) begin
                tick();
                check_obs("reset_abort", obsD, rstD);
            end
            resetN = 1'b1;
        end

        // Restarted sequence must match the power-on one.
        repeat (850) tick();
        check_int("restart_first_frame", dFs, 800);
        check_int("pulse_width_final", widthViol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
